// File: rtl/adder_operand_fifo_if.sv
// adder_operand_fifo_if
//
// Bundles the producer-side and consumer-side handshake signals of the
// adder operand FIFO.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// exactly when valid && ready are both 1 at that edge. valid never depends
// combinationally on ready. Data is only meaningful while valid is 1.
//
// Signals:
//   in_valid, in_a, in_b   producer -> FIFO, operand pair offered
//   in_ready               FIFO -> producer, space available (!full)
//   A, B, out_valid        FIFO -> adder/consumer, head entry (zeros when empty)
//   out_ready              consumer -> FIFO, result taken, pop head
//   count, full, empty     FIFO occupancy status
//
// Modports:
//   slave  - the FIFO itself
//   master - the environment driving producer inputs and consuming outputs
interface adder_operand_fifo_if #(
    parameter int Width = 8,
    parameter int Depth = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [Width-1:0]         in_a;
    logic [Width-1:0]         in_b;
    logic [Width-1:0]         A;
    logic [Width-1:0]         B;
    logic                     out_valid;
    logic                     out_ready;
    logic [$clog2(Depth):0]   count;
    logic                     full;
    logic                     empty;

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, A, B, out_valid, count, full, empty
    );

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, A, B, out_valid, count, full, empty
    );
endinterface

// File: rtl/adder_operand_fifo.sv
// adder_operand_fifo
//
// In-order buffer of (A, B) operand pairs placed directly in front of a
// combinational adder. The oldest stored pair drives A/B; the consumer
// samples the adder result C in the cycle it raises out_ready, which pops
// the head.
//
// Ports:
//   clk   single clock, rising edge
//   rst   synchronous active-low reset (0 = reset)
//   bus   adder_operand_fifo_if.slave (handshakes, head data, status)
//
// Behaviour notes:
//   - in_ready = !full; a push is refused while full even if a pop happens
//     in the same cycle (no pass-through).
//   - out_valid = !empty; a pushed pair is visible only after the edge that
//     writes it (no bypass).
//   - All outputs come from registers only, so A/B/out_valid never depend
//     combinationally on in_valid or out_ready.
module adder_operand_fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    adder_operand_fifo_if.slave   bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [2*Width-1:0] mem_q [Depth];
    logic [2*Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*Width-1:0] head;

    always_comb begin
        full     = (count_q == CntW'(Depth));
        empty    = (count_q == '0);
        push     = bus.in_valid && !full;
        pop      = !empty && bus.out_ready;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_a, bus.in_b};
            // Depth is a power of two, so the pointer wraps by overflow.
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers and occupancy: reset wins over any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; resetting the pointers discards it logically.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.A         = empty ? '0 : head[2*Width-1:Width];
    assign bus.B         = empty ? '0 : head[Width-1:0];
    assign bus.out_valid = !empty;
    assign bus.in_ready  = !full;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_adder_operand_fifo.sv
// Directed bench for adder_operand_fifo (Width=8, Depth=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, well away from the next active edge.
module tb_adder_operand_fifo;
    logic clk;
    logic rst;
    logic [7:0] c;

    int passed;
    int total;

    adder_operand_fifo_if #(.Width(8), .Depth(4)) bus ();

    adder_operand_fifo #(.Width(8), .Depth(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Model of the downstream combinational adder.
    assign c = bus.A + bus.B;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = 8'h00;
        bus.in_b     = 8'h00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else passed++;
        total++; if (bus.A !== 8'h00) $display("FAIL reset_A: got %h expected 00", bus.A); else passed++;
        total++; if (bus.B !== 8'h00) $display("FAIL reset_B: got %h expected 00", bus.B); else passed++;
        total++; if (bus.count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", bus.count); else passed++;
        total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", bus.empty); else passed++;
        total++; if (bus.full !== 1'b0) $display("FAIL reset_full: got %b expected 0", bus.full); else passed++;
    endtask

    task automatic test_single_transfer();
        bus.in_a     = 8'h12;
        bus.in_b     = 8'h34;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) $display("FAIL single_out_valid: got %b expected 1", bus.out_valid); else passed++;
        total++; if (bus.A !== 8'h12) $display("FAIL single_A: got %h expected 12", bus.A); else passed++;
        total++; if (bus.B !== 8'h34) $display("FAIL single_B: got %h expected 34", bus.B); else passed++;
        total++; if (bus.count !== 3'd1) $display("FAIL single_count: got %0d expected 1", bus.count); else passed++;
        total++; if (c !== 8'h46) $display("FAIL single_C: got %h expected 46", c); else passed++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.empty !== 1'b1) $display("FAIL single_pop_empty: got %b expected 1", bus.empty); else passed++;
        total++; if (bus.A !== 8'h00 || bus.B !== 8'h00)
            $display("FAIL single_pop_AB: got %h/%h expected 00/00", bus.A, bus.B); else passed++;
    endtask

    task automatic test_fill_overflow();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.in_a     = 8'(k);
            bus.in_b     = 8'(k);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        total++; if (bus.full !== 1'b1) $display("FAIL fill_full: got %b expected 1", bus.full); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b expected 0", bus.in_ready); else passed++;
        total++; if (bus.count !== 3'd4) $display("FAIL fill_count: got %0d expected 4", bus.count); else passed++;
        bus.in_a     = 8'h09;
        bus.in_b     = 8'h09;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd4) $display("FAIL overflow_count: got %0d expected 4", bus.count); else passed++;
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.A !== 8'(k) || bus.B !== 8'(k))
                $display("FAIL drain_entry%0d: got v=%b %h/%h expected v=1 %h/%h", k, bus.out_valid, bus.A, bus.B, 8'(k), 8'(k));
            else passed++;
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.empty !== 1'b1 || bus.A !== 8'h00)
            $display("FAIL drain_empty: got empty=%b A=%h expected empty=1 A=00", bus.empty, bus.A); else passed++;
    endtask

    task automatic test_full_pop();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.in_a     = 8'(k);
            bus.in_b     = 8'(k);
            bus.in_valid = 1'b1;
            tick();
        end
        total++; if (bus.count !== 3'd4) $display("FAIL fullpop_pre_count: got %0d expected 4", bus.count); else passed++;
        bus.in_a      = 8'h05;
        bus.in_b      = 8'h05;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd3) $display("FAIL fullpop_count: got %0d expected 3", bus.count); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL fullpop_in_ready: got %b expected 1", bus.in_ready); else passed++;
        total++; if (bus.A !== 8'h02) $display("FAIL fullpop_head: got %h expected 02", bus.A); else passed++;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.count !== 3'd4 || bus.full !== 1'b1)
            $display("FAIL fullpop_accept: got count=%0d full=%b expected 4/1", bus.count, bus.full); else passed++;
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            total++; if (bus.A !== 8'(k) || bus.B !== 8'(k))
                $display("FAIL fullpop_drain%0d: got %h/%h expected %h/%h", k, bus.A, bus.B, 8'(k), 8'(k));
            else passed++;
            tick();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.empty !== 1'b1) $display("FAIL fullpop_empty: got %b expected 1", bus.empty); else passed++;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_a = 8'(k);
            bus.in_b = 8'(8'hFF - k);
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.A !== 8'(k) || bus.B !== 8'(8'hFF - k) || bus.count !== 3'd1)
                $display("FAIL stream_%0d: got v=%b %h/%h cnt=%0d expected v=1 %h/%h cnt=1",
                         k, bus.out_valid, bus.A, bus.B, bus.count, 8'(k), 8'(8'hFF - k));
            else passed++;
            total++; if (c !== 8'hFF) $display("FAIL stream_C%0d: got %h expected ff", k, c); else passed++;
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.empty !== 1'b1 || bus.count !== 3'd0)
            $display("FAIL stream_end: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.in_a     = 8'(8'h30 + k);
            bus.in_b     = 8'(8'h40 + k);
            bus.in_valid = 1'b1;
            tick();
        end
        total++; if (bus.count !== 3'd3) $display("FAIL rstmid_pre_count: got %0d expected 3", bus.count); else passed++;
        rst           = 1'b0;
        bus.in_a      = 8'h77;
        bus.in_b      = 8'h77;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (bus.count !== 3'd0) $display("FAIL rstmid_count: got %0d expected 0", bus.count); else passed++;
        total++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL rstmid_empty: got empty=%b v=%b expected 1/0", bus.empty, bus.out_valid); else passed++;
        total++; if (bus.A !== 8'h00 || bus.B !== 8'h00)
            $display("FAIL rstmid_AB: got %h/%h expected 00/00", bus.A, bus.B); else passed++;
        bus.in_a     = 8'hA5;
        bus.in_b     = 8'h5A;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.A !== 8'hA5 || bus.B !== 8'h5A || bus.count !== 3'd1)
            $display("FAIL rstmid_first: got %h/%h cnt=%0d expected a5/5a cnt=1", bus.A, bus.B, bus.count); else passed++;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.empty !== 1'b1) $display("FAIL rstmid_final_empty: got %b expected 1", bus.empty); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_single_transfer();
        test_fill_overflow();
        test_full_pop();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
